fp32_booth_multiplier: RTL and testbench

Sequential IEEE-754 single-precision multiplier built on radix-4 Booth recoding. It is the forward-direction companion to the SRT FP32 divider and sits beside it in the FPU_32 datapath. It uses the same 24-bit mantissa, guard/round/sticky rounding and flag conventions, so quotients can be checked by re-multiplication. Operands are accepted over a valid/ready handshake, iterated for 13 cycles, then normalized, rounded and held until consumed.

---
 rtl/fp32_pkg.sv | 30 +++
 rtl/booth_r4_pp_gen.sv | 25 ++
 rtl/fp32_booth_multiplier.sv | 205 ++++++++++++++++++++
 tb/tb_fp32_booth_multiplier.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Shared FP32 definitions for the FPU_32 multiplier and divider.
package fp32_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  localparam int          BIAS    = 127;
  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam int          EXP_MAX = 255;

  // Bit positions inside the 5-bit flags word {invalid, overflow, underflow, inexact, zero}
  localparam int FLAG_INVALID   = 4;
  localparam int FLAG_OVERFLOW  = 3;
  localparam int FLAG_UNDERFLOW = 2;
  localparam int FLAG_INEXACT   = 1;
  localparam int FLAG_ZERO      = 0;

  localparam int ITER_LAST = 12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ITER,
    ST_ROUND,
    ST_DONE
  } state_e;

endpackage

// File: rtl/booth_r4_pp_gen.sv
// Radix-4 Booth partial product: selects 0, +/-Ma or +/-2Ma from a 3-bit multiplier window.
module booth_r4_pp_gen (
  input  logic [2:0]         i_y,
  input  logic [23:0]        i_ma,
  output logic signed [26:0] o_pp
);

  logic signed [26:0] w_ma_x1;
  logic signed [26:0] w_ma_x2;

  assign w_ma_x1 = $signed({3'b000, i_ma});
  assign w_ma_x2 = $signed({2'b00, i_ma, 1'b0});

  always_comb begin
    o_pp = '0;
    case (i_y)
      3'b001, 3'b010: o_pp = w_ma_x1;
      3'b011:         o_pp = w_ma_x2;
      3'b100:         o_pp = -w_ma_x2;
      3'b101, 3'b110: o_pp = -w_ma_x1;
      default:        o_pp = '0;
    endcase
  end

endmodule

// File: rtl/fp32_booth_multiplier.sv
// Sequential FP32 multiplier: 13-step radix-4 Booth accumulation, then one round-to-nearest-even step.
module fp32_booth_multiplier
  import fp32_pkg::*;
#(
  parameter int FTZ = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] product,
  output logic [4:0]  flags
);

  generate
    if (FTZ != 1) begin : g_ftz_check
      $error("fp32_booth_multiplier: subnormal support (FTZ=0) is not implemented");
    end
  endgenerate

  state_e             r_state;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [31:0]        r_product;
  logic [4:0]         r_flags;
  logic [3:0]         r_cnt;
  logic [49:0]        r_p;
  logic [26:0]        r_y;
  logic [23:0]        r_ma;
  logic               r_sign;
  logic signed [9:0]  r_exp;

  fp32_t w_a;
  fp32_t w_b;
  assign w_a = a;
  assign w_b = b;

  logic w_a_nan, w_a_inf, w_a_zero;
  logic w_b_nan, w_b_inf, w_b_zero;
  logic w_sign;

  assign w_a_nan  = (w_a.exp == 8'(EXP_MAX)) && (w_a.frac != '0);
  assign w_a_inf  = (w_a.exp == 8'(EXP_MAX)) && (w_a.frac == '0);
  assign w_a_zero = (w_a.exp == '0);
  assign w_b_nan  = (w_b.exp == 8'(EXP_MAX)) && (w_b.frac != '0);
  assign w_b_inf  = (w_b.exp == 8'(EXP_MAX)) && (w_b.frac == '0);
  assign w_b_zero = (w_b.exp == '0);
  assign w_sign   = w_a.sign ^ w_b.sign;

  logic        w_special;
  logic [31:0] w_sp_product;
  logic [4:0]  w_sp_flags;

  // Subnormals count as zero here since the exponent field alone decides zero-ness
  always_comb begin
    w_special    = 1'b1;
    w_sp_product = '0;
    w_sp_flags   = '0;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_a_zero && w_b_inf)) begin
      w_sp_product             = QNAN;
      w_sp_flags[FLAG_INVALID] = 1'b1;
    end else if (w_a_inf || w_b_inf) begin
      w_sp_product = {w_sign, 8'(EXP_MAX), 23'd0};
    end else if (w_a_zero || w_b_zero) begin
      w_sp_product          = {w_sign, 31'd0};
      w_sp_flags[FLAG_ZERO] = 1'b1;
    end else begin
      w_special = 1'b0;
    end
  end

  logic signed [9:0] w_exp_init;
  assign w_exp_init = $signed({2'b00, w_a.exp}) + $signed({2'b00, w_b.exp}) - $signed(10'(BIAS));

  logic signed [26:0] w_pp;
  logic [49:0]        w_pp_ext;
  logic [49:0]        w_pp_aligned;

  booth_r4_pp_gen u_pp_gen (
    .i_y  (r_y[2:0]),
    .i_ma (r_ma),
    .o_pp (w_pp)
  );

  assign w_pp_ext     = {{23{w_pp[26]}}, w_pp};
  assign w_pp_aligned = w_pp_ext << {r_cnt, 1'b0};

  logic              w_norm;
  logic [23:0]       w_mant_pre;
  logic              w_g, w_r, w_s;
  logic              w_inc;
  logic [24:0]       w_mant_sum;
  logic              w_carry;
  logic [23:0]       w_mant_fin;
  logic signed [9:0] w_exp_n;
  logic signed [9:0] w_exp_fin;
  logic              w_inexact;
  logic [31:0]       w_rnd_product;
  logic [4:0]        w_rnd_flags;

  assign w_norm     = r_p[47];
  assign w_mant_pre = w_norm ? r_p[47:24] : r_p[46:23];
  assign w_g        = w_norm ? r_p[23] : r_p[22];
  assign w_r        = w_norm ? r_p[22] : r_p[21];
  assign w_s        = w_norm ? (|r_p[21:0]) : (|r_p[20:0]);
  assign w_inc      = w_g && (w_r || w_s || w_mant_pre[0]);
  assign w_mant_sum = {1'b0, w_mant_pre} + {24'd0, w_inc};
  assign w_carry    = w_mant_sum[24];
  assign w_mant_fin = w_carry ? 24'h800000 : w_mant_sum[23:0];
  assign w_exp_n    = r_exp + $signed({9'd0, w_norm});
  assign w_exp_fin  = w_exp_n + $signed({9'd0, w_carry});
  assign w_inexact  = w_g | w_r | w_s;

  always_comb begin
    w_rnd_product = {r_sign, w_exp_fin[7:0], w_mant_fin[22:0]};
    w_rnd_flags   = '0;
    w_rnd_flags[FLAG_INEXACT] = w_inexact;
    if (w_exp_fin >= $signed(10'(EXP_MAX))) begin
      w_rnd_product               = {r_sign, 8'(EXP_MAX), 23'd0};
      w_rnd_flags                 = '0;
      w_rnd_flags[FLAG_OVERFLOW]  = 1'b1;
      w_rnd_flags[FLAG_INEXACT]   = 1'b1;
    end else if (w_exp_fin <= 10'sd0) begin
      w_rnd_product               = {r_sign, 31'd0};
      w_rnd_flags                 = '0;
      w_rnd_flags[FLAG_UNDERFLOW] = 1'b1;
      w_rnd_flags[FLAG_ZERO]      = 1'b1;
      w_rnd_flags[FLAG_INEXACT]   = (r_p != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_product   <= '0;
      r_flags     <= '0;
      r_cnt       <= '0;
      r_p         <= '0;
      r_y         <= '0;
      r_ma        <= '0;
      r_sign      <= 1'b0;
      r_exp       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_sign     <= w_sign;
            r_in_ready <= 1'b0;
            if (w_special) begin
              r_product   <= w_sp_product;
              r_flags     <= w_sp_flags;
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_ma    <= {|w_a.exp, w_a.frac};
              r_y     <= {2'b00, 1'b1, w_b.frac, 1'b0};
              r_p     <= '0;
              r_cnt   <= '0;
              r_exp   <= w_exp_init;
              r_state <= ST_ITER;
            end
          end
        end
        ST_ITER: begin
          r_p <= r_p + w_pp_aligned;
          r_y <= {2'b00, r_y[26:2]};
          if (r_cnt == 4'(ITER_LAST)) begin
            r_cnt   <= '0;
            r_state <= ST_ROUND;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ST_ROUND: begin
          r_product   <= w_rnd_product;
          r_flags     <= w_rnd_flags;
          r_out_valid <= 1'b1;
          r_state     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign product   = r_product;
  assign flags     = r_flags;

endmodule

// File: tb/tb_fp32_booth_multiplier.sv
// Directed bench for fp32_booth_multiplier with a value-level FP32 reference model and scoreboard.
module tb_fp32_booth_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] product;
  logic [4:0]  flags;

  fp32_booth_multiplier dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  int pop_cyc  = 0;
  bit head_seen = 1'b0;

  typedef struct {
    logic [31:0] prod;
    logic [4:0]  flg;
    int          lat;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ep;
    logic [4:0]  ef;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic note_fail(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired (cycle %0d)", nm, cyc);
  endtask

  // Reference: exact integer product of significands, rounded by remainder-vs-half comparison.
  // Returns {special, product, flags}.
  function automatic logic [37:0] model(input logic [31:0] x, input logic [31:0] y);
    logic s;
    logic [7:0] ex, ey;
    logic [22:0] fx, fy;
    bit xn, yn, xi, yi, xz, yz;
    longint unsigned m, q, rem, half;
    int e, sh;
    s  = x[31] ^ y[31];
    ex = x[30:23]; fx = x[22:0];
    ey = y[30:23]; fy = y[22:0];
    xn = (ex == 8'hFF) && (fx != 0); xi = (ex == 8'hFF) && (fx == 0); xz = (ex == 0);
    yn = (ey == 8'hFF) && (fy != 0); yi = (ey == 8'hFF) && (fy == 0); yz = (ey == 0);
    if (xn || yn || (xi && yz) || (xz && yi)) return {1'b1, 32'h7FC00000, 5'b10000};
    if (xi || yi) return {1'b1, s, 8'hFF, 23'd0, 5'b00000};
    if (xz || yz) return {1'b1, s, 31'd0, 5'b00001};
    m  = 64'({1'b1, fx}) * 64'({1'b1, fy});
    e  = int'(ex) + int'(ey) - 127;
    sh = 23;
    if (m >= (64'd1 << 47)) begin
      sh = 24;
      e++;
    end
    q    = m >> sh;
    rem  = m - (q << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q++;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e++;
    end
    if (e >= 255) return {1'b0, s, 8'hFF, 23'd0, 5'b01010};
    if (e <= 0)   return {1'b0, s, 31'd0, 5'b00111};
    return {1'b0, s, 8'(e), q[22:0], 3'b000, (rem != 0), 1'b0};
  endfunction

  // Single compare/scoreboard process, sampling #1 after each falling edge.
  initial begin
    logic [37:0] mv;
    exp_t        e;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (rst && out_valid) begin
        if (exp_q.size() == 0) begin
          note_fail("unexpected_result");
        end else begin
          check("product", product, exp_q[0].prod);
          check("flags", 32'(flags), 32'(exp_q[0].flg));
          check("in_ready_while_done", 32'(in_ready), 32'd0);
          if (!head_seen) begin
            check("latency", 32'(cyc - acc_cyc), 32'(exp_q[0].lat));
            head_seen = 1'b1;
          end
        end
      end
      if (!rst) begin
        exp_q.delete();
        head_seen = 1'b0;
      end else begin
        if (out_valid && out_ready && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          head_seen = 1'b0;
          pop_cyc   = cyc;
        end
        if (in_valid && in_ready) begin
          mv     = model(a, b);
          e.prod = mv[36:5];
          e.flg  = mv[4:0];
          e.lat  = mv[37] ? 1 : 15;
          exp_q.push_back(e);
          acc_cyc = cyc;
        end
      end
    end
  end

  task automatic issue(input logic [31:0] xa, input logic [31:0] xb);
    int n;
    n = 0;
    @(negedge clk);
    a = xa;
    b = xb;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) note_fail("issue_wait");
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input logic [31:0] ep, input logic [4:0] ef);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      note_fail("result_wait");
    end else begin
      check("literal_product", product, ep);
      check("literal_flags", 32'(flags), 32'(ef));
    end
    $display("op %h x %h -> %h flags %b", a, b, product, flags);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_after_release", 32'(out_valid), 32'd0);
    check("in_ready_after_release", 32'(in_ready), 32'd1);
  endtask

  vec_t vecs[16];
  logic [37:0] pin;

  initial begin
    vecs[0]  = '{32'h3FC00000, 32'h40000000, 32'h40400000, 5'b00000};
    vecs[1]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 5'b00010};
    vecs[2]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 5'b10000};
    vecs[3]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 5'b00000};
    vecs[4]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 5'b01010};
    vecs[5]  = '{32'h00800000, 32'h00800000, 32'h00000000, 5'b00111};
    vecs[6]  = '{32'hC0000000, 32'h40400000, 32'hC0C00000, 5'b00000};
    vecs[7]  = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 5'b10000};
    vecs[8]  = '{32'h80000000, 32'h3F800000, 32'h80000000, 5'b00001};
    vecs[9]  = '{32'h3F800000, 32'h00000001, 32'h00000000, 5'b00001};
    vecs[10] = '{32'h3F800000, 32'h7F7FFFFF, 32'h7F7FFFFF, 5'b00000};
    vecs[11] = '{32'h3F000000, 32'h01000000, 32'h00800000, 5'b00000};
    vecs[12] = '{32'h3F000000, 32'h00800000, 32'h00000000, 5'b00111};
    vecs[13] = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 5'b00010};
    vecs[14] = '{32'h3F800003, 32'h3FC00000, 32'h3FC00004, 5'b00010};
    vecs[15] = '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 5'b00010};

    // Pin the reference model on hand-worked rounding cases
    pin = model(32'h3F800001, 32'h3FC00000);
    check("model_tie_odd", pin[36:5], 32'h3FC00002);
    pin = model(32'h3F800003, 32'h3FC00000);
    check("model_tie_even", pin[36:5], 32'h3FC00004);
    pin = model(32'h7F000000, 32'h7F000000);
    check("model_overflow", {pin[36:5]}, 32'h7F800000);

    repeat (3) @(negedge clk);
    rst = 1'b1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_product", product, 32'd0);
    check("reset_flags", 32'(flags), 32'd0);

    for (int i = 0; i < 16; i++) begin
      issue(vecs[i].a, vecs[i].b);
      wait_result(vecs[i].ep, vecs[i].ef);
      release_out();
    end

    // Back-pressure: result held while in_valid pulses are ignored
    issue(32'h3FC00000, 32'h40000000);
    wait_result(32'h40400000, 5'b00000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0];
      a = 32'h40800000;
      b = 32'h40800000;
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = 32'h40000000;
    b = 32'h40400000;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_in_ready_after_release", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_accept_gap", 32'(acc_cyc - pop_cyc), 32'd1);
    wait_result(32'h40C00000, 5'b00000);
    release_out();

    // Reset during ITER: aborted result must never appear
    issue(32'h3FC00000, 32'h40000000);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("midreset_product", product, 32'd0);
    check("midreset_flags", 32'(flags), 32'd0);
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    check("midreset_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("midreset_no_result", 32'(out_valid), 32'd0);
    end
    issue(32'h40000000, 32'h40400000);
    wait_result(32'h40C00000, 5'b00000);
    release_out();

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
